// File: rtl/jk_cmd_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jk_cmd_seq_pkg
// Brief    : JK opcode and sequencer state encodings shared by the command
//            sequencer and the JK flip-flop bench, plus the JK next-state rule.
// Revision : 1.0 - initial release
// ============================================================================
package jk_cmd_seq_pkg;

    // JK opcode as driven onto {j,k}
    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_op_e;

    // Sequencer states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } seq_state_e;

    // Next q of a JK flip-flop given current q and the {j,k} pair
    function automatic logic jk_next(input logic q, input logic [1:0] jk);
        logic r;
        case (jk)
            2'b00:   r = q;
            2'b01:   r = 1'b0;
            2'b10:   r = 1'b1;
            default: r = ~q;
        endcase
        return r;
    endfunction

endpackage : jk_cmd_seq_pkg
`default_nettype wire

// File: rtl/jk_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : jk_cmd_fifo
// Brief    : Synchronous FIFO holding queued JK commands. Head entry is shown
//            combinationally on dout; flush empties it on the next clock.
// Revision : 1.0 - initial release
// ============================================================================
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] C_PTR_ONE  = AW'(1);
    localparam logic [AW:0]   C_LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   C_LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    // Overflow/underflow are blocked here so callers cannot corrupt state
    assign w_push = push & ~full  & ~flush;
    assign w_pop  = pop  & ~empty & ~flush;

    assign full  = (r_level == C_LVL_FULL);
    assign empty = (r_level == '0);
    assign level = r_level;
    assign dout  = r_mem[r_rd_ptr];

    // Storage write; contents need no reset since level gates visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + C_LVL_ONE;
                2'b01:   r_level <= r_level - C_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule : jk_cmd_fifo
`default_nettype wire

// File: rtl/jk_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : jk_cmd_seq
// Brief    : Queues {op,len} commands and drives a downstream JK flip-flop
//            with op for max(len,1) cycles each, back to back, while
//            tracking the flip-flop's expected output.
// Revision : 1.0 - initial release
// ============================================================================
module jk_cmd_seq
    import jk_cmd_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     cmd_valid,
    input  logic [1:0]               cmd_op,
    input  logic [LEN_W-1:0]         cmd_len,
    output logic                     cmd_ready,
    output logic                     j,
    output logic                     k,
    output logic                     exp_q,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int CW = 2 + LEN_W;
    localparam logic [LEN_W-1:0] C_CNT_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] C_CNT_TWO = LEN_W'(2);

    logic [CW-1:0]    w_head;
    logic [1:0]       w_head_op;
    logic [LEN_W-1:0] w_head_cnt;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_push;
    logic             w_pop;

    seq_state_e       r_state;
    seq_state_e       w_state_nxt;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_cnt_nxt;
    logic             r_j;
    logic             r_k;
    logic             w_j_nxt;
    logic             w_k_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_exp_q;

    // Ready depends only on occupancy, never on same-cycle valid or pop
    assign cmd_ready = ~w_fifo_full;
    assign w_push    = cmd_valid & cmd_ready & ~flush;

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (w_push),
        .din   ({cmd_op, cmd_len}),
        .pop   (w_pop),
        .dout  (w_head),
        .level (level),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // Zero length is issued for one cycle
    assign w_head_op  = w_head[CW-1 -: 2];
    assign w_head_cnt = (w_head[LEN_W-1:0] == '0) ? C_CNT_ONE : w_head[LEN_W-1:0];

    // Next-state / output decode; the last issue cycle can pop the next
    // command directly so consecutive commands run without a 00 gap
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_j_nxt     = r_j;
        w_k_nxt     = r_k;
        w_done_nxt  = 1'b0;
        w_pop       = 1'b0;
        if (flush) begin
            w_state_nxt        = ST_IDLE;
            {w_j_nxt, w_k_nxt} = JK_HOLD;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_fifo_empty) begin
                        w_pop              = 1'b1;
                        w_state_nxt        = ST_ISSUE;
                        w_cnt_nxt          = w_head_cnt;
                        {w_j_nxt, w_k_nxt} = w_head_op;
                        w_done_nxt         = (w_head_cnt == C_CNT_ONE);
                    end else begin
                        {w_j_nxt, w_k_nxt} = JK_HOLD;
                    end
                end
                ST_ISSUE: begin
                    if (r_cnt == C_CNT_ONE) begin
                        if (!w_fifo_empty) begin
                            w_pop              = 1'b1;
                            w_cnt_nxt          = w_head_cnt;
                            {w_j_nxt, w_k_nxt} = w_head_op;
                            w_done_nxt         = (w_head_cnt == C_CNT_ONE);
                        end else begin
                            w_state_nxt        = ST_IDLE;
                            {w_j_nxt, w_k_nxt} = JK_HOLD;
                        end
                    end else begin
                        w_cnt_nxt  = r_cnt - C_CNT_ONE;
                        w_done_nxt = (r_cnt == C_CNT_TWO);
                    end
                end
                default: begin
                    w_state_nxt        = ST_IDLE;
                    {w_j_nxt, w_k_nxt} = JK_HOLD;
                end
            endcase
        end
    end

    // State and registered outputs; the shadow q always follows the
    // {j,k} actually presented this cycle, flush included
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_j     <= 1'b0;
            r_k     <= 1'b0;
            r_done  <= 1'b0;
            r_exp_q <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_j     <= w_j_nxt;
            r_k     <= w_k_nxt;
            r_done  <= w_done_nxt;
            r_exp_q <= jk_next(r_exp_q, {r_j, r_k});
        end
    end

    assign j     = r_j;
    assign k     = r_k;
    assign done  = r_done;
    assign exp_q = r_exp_q;
    assign busy  = (r_state == ST_ISSUE);

endmodule : jk_cmd_seq
`default_nettype wire
